// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

  // Controller states: power-up sweep, idle/fetch, byte loading, partial-word flush.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Returned on any faulting fetch (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Width of a word index for a memory of depth_bytes bytes.
  function automatic int idx_w(input int depth_bytes);
    return $clog2(depth_bytes / 4);
  endfunction

endpackage

// File: rtl/imem_word_ram.sv
// Word RAM: one write port, one registered read port, no array reset.
// Latency: read data appears the cycle after rd_en; writes land at the edge.
// Backpressure: none, both ports accept every cycle.
// Ports: clk; wr_en/wr_idx/wr_data write port; rd_en/rd_idx read request;
//        rd_data holds the last read word until the next rd_en.
module imem_word_ram
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int IDX_W       = idx_w(DEPTH_BYTES)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  localparam int WORDS = DEPTH_BYTES / 4;

  logic [31:0] mem [WORDS];
  logic [31:0] rd_data_d;
  logic [31:0] rd_data_q;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_loader.sv
// Loadable instruction memory: post-reset zero sweep, byte-stream loader, registered fetch.
// Latency: fetch accepted at edge N returns fetch_valid during cycle N+1.
// Backpressure: fetch_ready only in IDLE; load_ready only in LOAD (no stall within a session).
// Ports: clk/reset (sync, active-low); fetch_req/fetch_addr -> fetch_ready,
//        fetch_valid/fetch_instr/fetch_fault; load_start/load_base, load_valid/load_byte
//        -> load_ready, load_end; load_err sticky per session; busy = not IDLE.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter bit RESET_SWEEP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  input  logic              load_end,
  output logic              load_err,
  output logic              busy
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = idx_w(DEPTH_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS - 1);
  // One extra bit so the range compare never truncates the limit.
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(DEPTH_BYTES);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;
  logic              load_err_q, load_err_d;
  logic              sess_bad_q, sess_bad_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              fetch_fault_q, fetch_fault_d;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       wr_data;
  logic              rd_en;
  logic [31:0]       rd_data;
  logic              word_commit;

  logic fetch_bad, base_bad, ptr_oob;
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_addr} >= DEPTH_LIM);
  assign base_bad  = (load_base[1:0]  != 2'b00) || ({1'b0, load_base}  >= DEPTH_LIM);
  assign ptr_oob   = ({1'b0, ptr_q} >= DEPTH_LIM);

  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    asm_d         = asm_q;
    load_err_d    = load_err_q;
    sess_bad_d    = sess_bad_q;
    fetch_valid_d = 1'b0;
    fetch_fault_d = 1'b0;
    fetch_ready   = 1'b0;
    load_ready    = 1'b0;
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = ptr_q[IDX_W+1:2];
    wr_data       = asm_q;
    word_commit   = 1'b0;

    case (state_q)
      CLEAR: begin
        wr_en     = 1'b1;
        wr_idx    = clr_idx_q;
        wr_data   = 32'h0;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == LAST_IDX) state_d = IDLE;
      end
      IDLE: begin
        fetch_ready = 1'b1;
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_fault_d = fetch_bad;
          // Faulting addresses never reach the array.
          rd_en         = !fetch_bad;
        end
        if (load_start) begin
          state_d    = LOAD;
          cnt_d      = 2'd0;
          asm_d      = 32'h0;
          ptr_d      = load_base;
          load_err_d = base_bad;
          sess_bad_d = base_bad;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (cnt_q == 2'd3) begin
            wr_data     = {asm_q[31:8], load_byte};
            word_commit = 1'b1;
            cnt_d       = 2'd0;
            asm_d       = 32'h0;
          end else begin
            case (cnt_q)
              2'd0:    asm_d[31:24] = load_byte;
              2'd1:    asm_d[23:16] = load_byte;
              default: asm_d[15:8]  = load_byte;
            endcase
            cnt_d = cnt_q + 2'd1;
          end
        end
        if (load_end) state_d = FLUSH;
      end
      FLUSH: begin
        // Unfilled byte lanes are already zero, so asm_q is the padded word.
        if (cnt_q != 2'd0) word_commit = 1'b1;
        cnt_d   = 2'd0;
        asm_d   = 32'h0;
        state_d = IDLE;
      end
      default: ;
    endcase

    // A bad-base session consumes bytes but never writes. Out-of-range words are
    // dropped and the pointer is held, so it can never wrap back into range.
    if (word_commit && !sess_bad_q) begin
      if (ptr_oob) begin
        load_err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        ptr_d = ptr_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RESET_SWEEP ? CLEAR : IDLE;
      clr_idx_q     <= '0;
      ptr_q         <= '0;
      cnt_q         <= 2'd0;
      asm_q         <= 32'h0;
      load_err_q    <= 1'b0;
      sess_bad_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      asm_q         <= asm_d;
      load_err_q    <= load_err_d;
      sess_bad_q    <= sess_bad_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  // Writes are blocked during reset so an in-flight word is discarded.
  imem_word_ram #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en & reset),
    .wr_idx (wr_idx),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_idx (fetch_addr[IDX_W+1:2]),
    .rd_data(rd_data)
  );

  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_instr = !fetch_valid_q ? 32'h0 : (fetch_fault_q ? NOP_INSTR : rd_data);
  assign load_err    = load_err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int WORDS = DEPTH / 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_fault;
  logic        load_start;
  logic [31:0] load_base;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic        load_end;
  logic        load_err;
  logic        busy;

  imem_loader #(
    .DEPTH_BYTES(DEPTH),
    .ADDR_W     (32),
    .RESET_SWEEP(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_fault(fetch_fault),
    .load_start (load_start),
    .load_base  (load_base),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_end   (load_end),
    .load_err   (load_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] mdl [WORDS];
  bit          mdl_err;
  logic [7:0]  sb [$];

  typedef struct {
    int          cyc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;
  exp_t q [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_fetch(input logic [31:0] a, output logic f);
    f = (a[1:0] != 2'b00) || (a >= 32'(DEPTH));
    return f ? 32'h0000_0013 : mdl[a[5:2]];
  endfunction

  // Apply a finished session to the model: bytes in ascending address order,
  // big-endian within a word, trailing partial word zero padded.
  function automatic void apply_session(input logic [31:0] base);
    longint      p;
    logic [31:0] word;
    int          n = sb.size();
    bit          bad = (base[1:0] != 2'b00) || (base >= 32'(DEPTH));
    mdl_err = bad;
    if (!bad) begin
      p = longint'(base);
      for (int w = 0; w * 4 < n; w++) begin
        word = 32'h0;
        for (int k = 0; k < 4; k++)
          if (w * 4 + k < n) word = word | ({24'h0, sb[w*4+k]} << (24 - 8 * k));
        if (p < DEPTH) mdl[int'(p >> 2)] = word;
        else mdl_err = 1'b1;
        p += 4;
      end
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < WORDS; i++) mdl[i] = 32'h0;
    mdl_err = 1'b0;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit   exp_v;
      exp_t e;
      exp_v = 1'b0;
      if (q.size() > 0) if (q[0].cyc == cyc - 1) exp_v = 1'b1;
      check("fetch_valid", fetch_valid, exp_v);
      if (exp_v) begin
        e = q.pop_front();
        check("fetch_instr", fetch_instr, e.instr);
        check("fetch_fault", fetch_fault, e.fault);
      end
    end
  end

  // ---------------- drivers (called just after a negedge) ----------------
  task automatic push_fetch(input logic [31:0] a);
    exp_t e;
    logic f;
    e.cyc   = cyc;
    e.instr = model_fetch(a, f);
    e.fault = f;
    q.push_back(e);
    fetch_req  = 1'b1;
    fetch_addr = a;
  endtask

  task automatic fetch_burst(input logic [31:0] addrs [$]);
    foreach (addrs[i]) begin
      check("fetch_ready", fetch_ready, 1);
      push_fetch(addrs[i]);
      @(negedge clk);
    end
    fetch_req = 1'b0;
  endtask

  task automatic fetch1(input logic [31:0] a);
    logic [31:0] aq [$];
    aq.push_back(a);
    fetch_burst(aq);
  endtask

  task automatic load_session(input logic [31:0] base, input bit with_fetch,
                              input logic [31:0] faddr, input bit end_with_byte);
    int n = sb.size();
    int k;
    check("idle_before_load", fetch_ready, 1);
    load_start = 1'b1;
    load_base  = base;
    if (with_fetch) push_fetch(faddr);
    @(negedge clk);
    load_start = 1'b0;
    fetch_req  = 1'b0;
    check("load_ready", load_ready, 1);
    check("busy_load", busy, 1);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) begin
        load_valid = 1'b0;
        load_byte  = 8'($urandom);
        load_start = 1'($urandom);
        load_base  = $urandom;
        @(negedge clk);
      end
      check("load_ready_byte", load_ready, 1);
      load_valid = 1'b1;
      load_byte  = sb[i];
      load_start = 1'($urandom);
      load_base  = $urandom;
      if (i == n - 1 && end_with_byte) load_end = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      load_start = 1'b0;
    end
    if (!(n > 0 && end_with_byte)) begin
      load_end = 1'b1;
      @(negedge clk);
    end
    load_end = 1'b0;
    check("flush_load_ready", load_ready, 0);
    check("flush_busy", busy, 1);
    k = 0;
    while (fetch_ready !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("return_idle", fetch_ready, 1);
    apply_session(base);
    check("load_err", load_err, mdl_err);
  endtask

  task automatic wait_sweep();
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sweep_cycles", n, 16);
    check("ready_after_sweep", fetch_ready, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 6)  return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    if (r == 6) return {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
    if (r == 7) return 32'(DEPTH) + 4 * $urandom_range(0, 7);
    if (r == 8) return $urandom;
    return 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] rand_base();
    int r = $urandom_range(0, 9);
    if (r < 7)  return {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    if (r == 7) return {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
    if (r == 8) return 32'(DEPTH) + 4 * $urandom_range(0, 3);
    return 32'h38 + 4 * $urandom_range(0, 1);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] aq [$];
    logic        f;

    reset = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0;
    load_start = 1'b0; load_base = 32'h0; load_valid = 1'b0;
    load_byte = 8'h0; load_end = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_fetch_ready", fetch_ready, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_instr", fetch_instr, 0);
    check("rst_fetch_fault", fetch_fault, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_err", load_err, 0);
    check("rst_busy", busy, 1);
    reset = 1'b1;
    wait_sweep();

    fetch1(32'h3C);
    check("model_3c", model_fetch(32'h3C, f), 32'h0);

    // Full word.
    sb.delete(); sb.push_back(8'h00); sb.push_back(8'h40); sb.push_back(8'h80); sb.push_back(8'h93);
    load_session(32'h0, 1'b0, 32'h0, 1'b0);
    check("model_word0", mdl[0], 32'h0040_8093);
    fetch1(32'h0);

    // Partial word with padding, load_end on the last byte.
    sb.delete(); sb.push_back(8'hAA); sb.push_back(8'hBB);
    load_session(32'h8, 1'b0, 32'h0, 1'b1);
    check("model_word2", mdl[2], 32'hAABB_0000);
    fetch1(32'h8);

    // Faults, back to back.
    aq.delete(); aq.push_back(32'h2); aq.push_back(32'h40); aq.push_back(32'hFFFF_FFFC);
    aq.push_back(32'h0); aq.push_back(32'h3F);
    fetch_burst(aq);
    check("model_nop", model_fetch(32'h2, f), 32'h0000_0013);

    // Misaligned base: error, nothing written.
    sb.delete(); sb.push_back(8'h12); sb.push_back(8'h34); sb.push_back(8'h56); sb.push_back(8'h78);
    load_session(32'h3, 1'b0, 32'h0, 1'b0);
    check("bad_base_err", load_err, 1);
    aq.delete(); aq.push_back(32'h0); aq.push_back(32'h4);
    fetch_burst(aq);

    // Overflow past the end.
    sb.delete();
    for (int i = 1; i <= 8; i++) sb.push_back(8'(8'h11 * i));
    load_session(32'h3C, 1'b0, 32'h0, 1'b0);
    check("model_ovf_word", mdl[15], 32'h1122_3344);
    check("model_ovf_err", {31'h0, mdl_err}, 1);
    fetch1(32'h3C);

    // Fetch accepted together with load_start sees the old contents.
    sb.delete(); sb.push_back(8'hDE); sb.push_back(8'hAD); sb.push_back(8'hBE); sb.push_back(8'hEF);
    load_session(32'h20, 1'b1, 32'h20, 1'b1);
    fetch1(32'h20);

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        aq.delete();
        repeat ($urandom_range(1, 6)) aq.push_back(rand_addr());
        fetch_burst(aq);
      end else begin
        sb.delete();
        repeat ($urandom_range(0, 9)) sb.push_back(8'($urandom));
        load_session(rand_base(), 1'($urandom), rand_addr(), 1'($urandom));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    aq.delete();
    for (int i = 0; i < WORDS; i++) aq.push_back(32'(4 * i));
    fetch_burst(aq);

    // Reset after two bytes of a session.
    check("idle_before_abort", fetch_ready, 1);
    load_start = 1'b1; load_base = 32'h10;
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b1; load_byte = 8'hC1;
    @(negedge clk);
    load_byte = 8'hC2;
    @(negedge clk);
    load_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    wait_sweep();
    check("abort_load_err", load_err, 0);
    fetch1(32'h10);
    check("model_abort", model_fetch(32'h10, f), 32'h0);
    aq.delete(); aq.push_back(32'h0); aq.push_back(32'h8); aq.push_back(32'h3C);
    fetch_burst(aq);

    @(negedge clk);
    @(negedge clk);
    check("pending_fetches", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory for the single-cycle RISC-V core, replacing the fixed 256-byte, hard-coded-program store. Storage is word-organised and cleared by a hardware sweep after reset. A byte-stream loader port programs it at run time. The fetch port is registered, with ready/valid handshake and fault reporting for misaligned or out-of-range PCs. It sits between the PC register and the decoder; the loader side connects to the debug/UART bootstrap path.

## Interface
- DEPTH_BYTES, 1024: storage size in bytes; power of two, multiple of 4, minimum 16.
- ADDR_W, 32: fetch and load address width.
- RESET_SWEEP, 1: 1 = zero all words after reset; 0 = skip the sweep (contents undefined).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- fetch_req  in  1  fetch request; accepted when fetch_ready=1.
- fetch_addr  in  ADDR_W  byte address (PC) of the instruction.
- fetch_ready  out  1  block can accept a fetch this cycle.
- fetch_valid  out  1  one-cycle pulse; fetch_instr/fetch_fault are valid.
- fetch_instr  out  32  instruction word; byte at fetch_addr in bits 31:24 (big-endian within the word).
- fetch_fault  out  1  misaligned (addr[1:0]≠0) or addr ≥ DEPTH_BYTES.
- load_start  in  1  begin a load session at load_base.
- load_base  in  ADDR_W  byte address of the session; must be word aligned.
- load_valid  in  1  load_byte is valid.
- load_byte  in  8  program byte, stream order = ascending address.
- load_ready  out  1  a byte is accepted when load_valid & load_ready.
- load_end  in  1  close the session; a partial word is padded with 0x00 and written.
- load_err  out  1  sticky: bad base or out-of-range write; cleared by the next load_start.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: CLEAR, IDLE, LOAD, FLUSH.
- Reset (reset=0 sampled at a clk edge):
  - Outputs go to: fetch_ready=0, fetch_valid=0, fetch_instr=0, fetch_fault=0, load_ready=0, load_err=0, busy=1.
  - State goes to CLEAR. If RESET_SWEEP=0, state goes to IDLE and busy=0.
- CLEAR: writes 0 to one word per cycle, index 0..DEPTH_BYTES/4-1, then goes to IDLE.
- IDLE:
  - fetch_ready=1, load_ready=0.
  - load_start → LOAD. Byte counter is cleared and the write pointer is set to load_base.
  - If load_base is misaligned or ≥ DEPTH_BYTES: load_err=1 and no memory writes occur for the session, but bytes are still consumed.
- LOAD:
  - fetch_ready=0, load_ready=1.
  - Each accepted byte shifts into a 32-bit assembly register; the first byte lands in bits 31:24.
  - On the 4th byte the word is written at the pointer, the pointer advances by 4, and the counter returns to 0.
  - A write with pointer ≥ DEPTH_BYTES is dropped and sets load_err.
  - load_end → FLUSH. If the same cycle also carries an accepted byte, that byte is included.
- FLUSH: if counter ≠ 0, the padded partial word is written. Then → IDLE.
- load_start while in LOAD or FLUSH: ignored.
- Fetch:
  - Accepted in IDLE only.
  - In-range aligned address: returns the stored word, fault=0.
  - Faulting address: fetch_instr=0x00000013 (NOP) and fault=1. No out-of-bounds array index is ever formed.

## Timing
- Fetch latency: 1 cycle. A request accepted at edge N gives fetch_valid=1 during cycle N+1.
- Back-to-back fetches: one per cycle.
- fetch_valid deasserts the cycle after a pulse unless a new request was accepted.
- A fetch accepted in the same cycle as load_start completes normally. The memory is not written by that session before the read.
- Write-to-fetch: a word written at edge N is readable by a fetch accepted at edge N+1 or later.
- Sweep duration: DEPTH_BYTES/4 cycles. The IDLE transition happens on the edge after the last word is written.
- Reset mid-LOAD: the session is aborted, the partial word is discarded, and the sweep restarts.
- Pointer arithmetic is ADDR_W bits wide with no wrap. The range compare uses the full width.

## Structure
- Shared package imem_pkg holds:
  - the state enum (CLEAR, IDLE, LOAD, FLUSH);
  - NOP_INSTR = 32'h0000_0013;
  - the word-index width function clog2(DEPTH_BYTES/4).
- Sub-module imem_word_ram: single write port, one registered read port, depth DEPTH_BYTES/4 × 32. It infers block RAM and has no reset on the array. The controller FSM, loader and fault logic stay in the top.

## Test plan
- Reset, DEPTH_BYTES=64: busy=1 for 16 cycles after reset release, then fetch_ready=1. Fetch 0x3C → 0x00000000, fault=0.
- Load: base 0x0, bytes 00 40 80 93 then load_end. Fetch 0x0 → 0x00408093 one cycle after acceptance.
- Partial word: base 0x8, bytes AA BB then load_end. Fetch 0x8 → 0xAABB0000.
- Faults: fetch 0x2 → fault=1, instr 0x00000013. Fetch 0x40 with DEPTH=64 → fault=1. Load base 0x3 → load_err=1 and memory unchanged.
- Overflow: base 0x3C, 8 bytes. Word at 0x3C is written, the second word is dropped, load_err=1.
- Reset asserted after 2 of 4 bytes: no write occurs, the sweep restarts, and the word fetched afterwards is 0.
